// File: rtl/rf_wb_arbiter_pkg.sv
// Shared core types for the register-file writeback path: request record,
// source encoding and register-index helpers.
package rf_wb_arbiter_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned NUM_REGS  = 32;
  // Queue storage width; the arbiter's XLEN may be anything up to this.
  localparam int unsigned WB_DATA_W = 64;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LD  = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_IDX_W-1:0] idx);
    return NUM_REGS'(1) << idx;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Single-source writeback queue: DEPTH entries, wrapping pointers, occupancy count.
module wb_fifo
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clock,
  input  logic    reset,
  input  logic    push,
  input  wb_req_t push_req,
  input  logic    pop,
  output logic    ready,
  output logic    not_empty,
  output wb_req_t head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  wb_req_t          mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign ready     = (count < CNT_W'(DEPTH));
  assign not_empty = (count != '0);
  assign head      = mem[rd_ptr];
  assign do_push   = push & ready;
  assign do_pop    = pop & not_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_req;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: per-source queues, round-robin write port,
// and a pending-register scoreboard that stalls decode on RAW/WAW hazards.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned XLEN  = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 alu_valid,
  input  logic [REG_IDX_W-1:0] alu_rd,
  input  logic [XLEN-1:0]      alu_data,
  output logic                 alu_ready,
  input  logic                 ld_valid,
  input  logic [REG_IDX_W-1:0] ld_rd,
  input  logic [XLEN-1:0]      ld_data,
  output logic                 ld_ready,
  input  logic                 issue_valid,
  input  logic [REG_IDX_W-1:0] issue_rd,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  output logic                 stall,
  output logic                 write_enable,
  output logic [REG_IDX_W-1:0] addr_rd,
  output logic [XLEN-1:0]      data_rd
);

  wb_req_t alu_req, ld_req, alu_head, ld_head, win;
  logic    alu_push, ld_push, alu_pop, ld_pop;
  logic    alu_ne, ld_ne;
  wb_src_e last_grant, grant_src;

  logic [NUM_REGS-1:0] pending, set_mask, clr_mask;

  // x0 requests are consumed at accept but never queued.
  assign alu_push     = alu_valid & alu_ready & (alu_rd != '0);
  assign ld_push      = ld_valid & ld_ready & (ld_rd != '0);
  assign alu_req.rd   = alu_rd;
  assign alu_req.data = WB_DATA_W'(alu_data);
  assign ld_req.rd    = ld_rd;
  assign ld_req.data  = WB_DATA_W'(ld_data);

  wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (alu_push),
    .push_req  (alu_req),
    .pop       (alu_pop),
    .ready     (alu_ready),
    .not_empty (alu_ne),
    .head      (alu_head)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_ld_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (ld_push),
    .push_req  (ld_req),
    .pop       (ld_pop),
    .ready     (ld_ready),
    .not_empty (ld_ne),
    .head      (ld_head)
  );

  // Round-robin on a tie; a lone non-empty queue always wins.
  always_comb begin
    grant_src = SRC_ALU;
    if (ld_ne && (!alu_ne || (last_grant == SRC_ALU))) grant_src = SRC_LD;
  end

  assign write_enable = alu_ne | ld_ne;
  assign alu_pop      = write_enable & (grant_src == SRC_ALU);
  assign ld_pop       = write_enable & (grant_src == SRC_LD);
  assign win          = (grant_src == SRC_LD) ? ld_head : alu_head;
  assign addr_rd      = write_enable ? win.rd : '0;
  assign data_rd      = write_enable ? XLEN'(win.data) : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant <= SRC_LD;
    end else if (write_enable) begin
      last_grant <= grant_src;
    end
  end

  // Hazard detect and scoreboard update; a same-cycle set beats the clear.
  always_comb begin
    stall = (pending[rs1] && (rs1 != '0)) ||
            (pending[rs2] && (rs2 != '0)) ||
            (issue_valid && pending[issue_rd] && (issue_rd != '0));
    set_mask = '0;
    clr_mask = '0;
    if (issue_valid && !stall && (issue_rd != '0)) set_mask = reg_onehot(issue_rd);
    if (write_enable) clr_mask = reg_onehot(addr_rd);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vector table, reset-in-flight sequence,
// then randomized traffic against a queue-based expected-write model.
module tb_rf_wb_arbiter;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned XLEN  = 32;

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_valid, ld_valid, issue_valid;
  logic [4:0]  alu_rd, ld_rd, issue_rd, rs1, rs2;
  logic [31:0] alu_data, ld_data;
  logic        alu_ready, ld_ready, stall, write_enable;
  logic [4:0]  addr_rd;
  logic [31:0] data_rd;

  always #5 clock = ~clock;

  rf_wb_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock        (clock),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .alu_ready    (alu_ready),
    .ld_valid     (ld_valid),
    .ld_rd        (ld_rd),
    .ld_data      (ld_data),
    .ld_ready     (ld_ready),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .rs1          (rs1),
    .rs2          (rs2),
    .stall        (stall),
    .write_enable (write_enable),
    .addr_rd      (addr_rd),
    .data_rd      (data_rd)
  );

  typedef struct {
    logic av; logic [4:0] ard; logic [31:0] adat;
    logic lv; logic [4:0] lrd; logic [31:0] ldat;
    logic iv; logic [4:0] ird; logic [4:0] r1; logic [4:0] r2;
    logic e_ar; logic e_lr; logic e_we; logic [4:0] e_addr; logic [31:0] e_data; logic e_stall;
  } vec_t;

  typedef struct packed { logic [4:0] rd; logic [31:0] data; } ent_t;

  localparam int NVEC = 31;
  vec_t tbl [NVEC];
  int   n_vec  = 0;
  int   n_miss = 0;

  ent_t        aq[$];
  ent_t        lq[$];
  logic        m_last;
  logic [31:0] m_pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
      input logic av, input logic [4:0] ard, input logic [31:0] adat,
      input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
      input logic iv, input logic [4:0] ird, input logic [4:0] r1, input logic [4:0] r2,
      input logic e_ar, input logic e_lr, input logic e_we, input logic [4:0] e_addr,
      input logic [31:0] e_data, input logic e_stall);
    vec_t v;
    v.av = av; v.ard = ard; v.adat = adat; v.lv = lv; v.lrd = lrd; v.ldat = ldat;
    v.iv = iv; v.ird = ird; v.r1 = r1; v.r2 = r2;
    v.e_ar = e_ar; v.e_lr = e_lr; v.e_we = e_we; v.e_addr = e_addr;
    v.e_data = e_data; v.e_stall = e_stall;
    return v;
  endfunction

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                       input logic iv, input logic [4:0] ird, input logic [4:0] r1,
                       input logic [4:0] r2);
    alu_valid = av; alu_rd = ard; alu_data = adat;
    ld_valid = lv; ld_rd = lrd; ld_data = ldat;
    issue_valid = iv; issue_rd = ird; rs1 = r1; rs2 = r2;
  endtask

  function automatic logic [4:0] rnd_rd();
    if ($urandom_range(0, 7) == 0) return 5'd0;
    return 5'($urandom_range(1, 15));
  endfunction

  initial begin
    // av ard adat | lv lrd ldat | iv ird rs1 rs2 | ar lr we addr data stall
    tbl[0]  = mk(1, 1, 32'h11,       1, 2, 32'h22,   0, 0, 0, 0,  1, 1, 0, 0,  32'h0,        0);
    tbl[1]  = mk(0, 0, 0,            0, 0, 0,        0, 0, 0, 0,  1, 1, 1, 1,  32'h11,       0);
    tbl[2]  = mk(0, 0, 0,            0, 0, 0,        0, 0, 0, 0,  1, 1, 1, 2,  32'h22,       0);
    tbl[3]  = mk(0, 0, 0,            0, 0, 0,        0, 0, 0, 0,  1, 1, 0, 0,  32'h0,        0);
    tbl[4]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,        0, 0, 0, 0,  1, 1, 0, 0,  32'h0,        0);
    tbl[5]  = mk(0, 0, 0,            0, 0, 0,        0, 0, 0, 0,  1, 1, 1, 5,  32'hDEADBEEF, 0);
    tbl[6]  = mk(0, 0, 0,            0, 0, 0,        0, 0, 0, 0,  1, 1, 0, 0,  32'h0,        0);
    tbl[7]  = mk(1, 10, 32'hA10,     1, 20, 32'hB20, 0, 0, 0, 0,  1, 1, 0, 0,  32'h0,        0);
    tbl[8]  = mk(1, 11, 32'hA11,     1, 21, 32'hB21, 0, 0, 0, 0,  1, 1, 1, 20, 32'hB20,      0);
    tbl[9]  = mk(1, 12, 32'hA12,     0, 0, 0,        0, 0, 0, 0,  0, 1, 1, 10, 32'hA10,      0);
    tbl[10] = mk(0, 0, 0,            0, 0, 0,        0, 0, 0, 0,  1, 1, 1, 21, 32'hB21,      0);
    tbl[11] = mk(0, 0, 0,            0, 0, 0,        0, 0, 0, 0,  1, 1, 1, 11, 32'hA11,      0);
    tbl[12] = mk(0, 0, 0,            0, 0, 0,        0, 0, 0, 0,  1, 1, 0, 0,  32'h0,        0);
    tbl[13] = mk(0, 0, 0,            0, 0, 0,        1, 7, 0, 0,  1, 1, 0, 0,  32'h0,        0);
    tbl[14] = mk(0, 0, 0,            1, 7, 32'h77,   0, 0, 7, 0,  1, 1, 0, 0,  32'h0,        1);
    tbl[15] = mk(0, 0, 0,            0, 0, 0,        0, 0, 7, 0,  1, 1, 1, 7,  32'h77,       1);
    tbl[16] = mk(0, 0, 0,            0, 0, 0,        0, 0, 7, 0,  1, 1, 0, 0,  32'h0,        0);
    tbl[17] = mk(0, 0, 0,            0, 0, 0,        1, 9, 0, 0,  1, 1, 0, 0,  32'h0,        0);
    tbl[18] = mk(0, 0, 0,            0, 0, 0,        1, 9, 0, 0,  1, 1, 0, 0,  32'h0,        1);
    tbl[19] = mk(0, 0, 0,            0, 0, 0,        0, 0, 0, 9,  1, 1, 0, 0,  32'h0,        1);
    tbl[20] = mk(1, 9, 32'h99,       0, 0, 0,        0, 0, 0, 9,  1, 1, 0, 0,  32'h0,        1);
    tbl[21] = mk(0, 0, 0,            0, 0, 0,        0, 0, 0, 9,  1, 1, 1, 9,  32'h99,       1);
    tbl[22] = mk(0, 0, 0,            0, 0, 0,        0, 0, 0, 9,  1, 1, 0, 0,  32'h0,        0);
    tbl[23] = mk(1, 4, 32'h44,       0, 0, 0,        0, 0, 0, 0,  1, 1, 0, 0,  32'h0,        0);
    tbl[24] = mk(0, 0, 0,            0, 0, 0,        1, 4, 0, 0,  1, 1, 1, 4,  32'h44,       0);
    tbl[25] = mk(0, 0, 0,            0, 0, 0,        0, 0, 4, 0,  1, 1, 0, 0,  32'h0,        1);
    tbl[26] = mk(1, 4, 32'h45,       0, 0, 0,        0, 0, 4, 0,  1, 1, 0, 0,  32'h0,        1);
    tbl[27] = mk(0, 0, 0,            0, 0, 0,        0, 0, 4, 0,  1, 1, 1, 4,  32'h45,       1);
    tbl[28] = mk(0, 0, 0,            0, 0, 0,        0, 0, 4, 0,  1, 1, 0, 0,  32'h0,        0);
    tbl[29] = mk(1, 0, 32'hBAD,      1, 0, 32'hBAD0, 1, 0, 0, 0,  1, 1, 0, 0,  32'h0,        0);
    tbl[30] = mk(0, 0, 0,            0, 0, 0,        1, 0, 0, 0,  1, 1, 0, 0,  32'h0,        0);

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst.alu_ready", 32'(alu_ready), 32'd1);
    chk("rst.ld_ready",  32'(ld_ready),  32'd1);
    chk("rst.we",        32'(write_enable), 32'd0);
    chk("rst.addr",      32'(addr_rd),   32'd0);
    chk("rst.data",      data_rd,        32'd0);
    chk("rst.stall",     32'(stall),     32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i].av, tbl[i].ard, tbl[i].adat, tbl[i].lv, tbl[i].lrd, tbl[i].ldat,
            tbl[i].iv, tbl[i].ird, tbl[i].r1, tbl[i].r2);
      @(negedge clock);
      chk($sformatf("v%0d.alu_ready", i), 32'(alu_ready),    32'(tbl[i].e_ar));
      chk($sformatf("v%0d.ld_ready", i),  32'(ld_ready),     32'(tbl[i].e_lr));
      chk($sformatf("v%0d.we", i),        32'(write_enable), 32'(tbl[i].e_we));
      chk($sformatf("v%0d.addr", i),      32'(addr_rd),      32'(tbl[i].e_addr));
      chk($sformatf("v%0d.data", i),      data_rd,           tbl[i].e_data);
      chk($sformatf("v%0d.stall", i),     32'(stall),        32'(tbl[i].e_stall));
      @(posedge clock); #1;
    end

    // Load both queues, mark x3 pending, then reset while writes are queued.
    drive(1, 13, 32'hC13, 1, 14, 32'hD14, 1, 3, 0, 0);
    @(posedge clock); #1;
    drive(1, 15, 32'hC15, 1, 16, 32'hD16, 0, 0, 0, 0);
    @(posedge clock); #1;
    drive(0, 0, 0, 1, 17, 32'hD17, 0, 0, 0, 0);
    @(posedge clock); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
    @(negedge clock);
    chk("mid.pre_we",    32'(write_enable), 32'd1);
    chk("mid.pre_addr",  32'(addr_rd),      32'd16);
    chk("mid.pre_stall", 32'(stall),        32'd1);
    #1 reset = 1'b1;
    #1;
    chk("mid.we",        32'(write_enable), 32'd0);
    chk("mid.alu_ready", 32'(alu_ready),    32'd1);
    chk("mid.ld_ready",  32'(ld_ready),     32'd1);
    chk("mid.stall",     32'(stall),        32'd0);
    chk("mid.addr",      32'(addr_rd),      32'd0);
    chk("mid.data",      data_rd,           32'd0);
    @(posedge clock); #1;
    chk("mid.edge_we",   32'(write_enable), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("mid.after_we",    32'(write_enable), 32'd0);
    chk("mid.after_stall", 32'(stall),        32'd0);

    aq.delete();
    lq.delete();
    m_last = 1'b1;
    m_pend = '0;
    for (int c = 0; c < 300; c++) begin
      logic e_ar, e_lr, e_we, g_ld, e_stall;
      ent_t w;
      alu_valid   = ($urandom_range(0, 9) < 6);
      alu_rd      = rnd_rd();
      alu_data    = {4'hA, 28'($urandom)};
      ld_valid    = ($urandom_range(0, 9) < 6);
      ld_rd       = rnd_rd();
      ld_data     = {4'h5, 28'($urandom)};
      issue_valid = ($urandom_range(0, 3) == 0);
      issue_rd    = rnd_rd();
      rs1         = rnd_rd();
      rs2         = rnd_rd();
      @(negedge clock);
      e_ar  = (aq.size() < DEPTH);
      e_lr  = (lq.size() < DEPTH);
      e_we  = (aq.size() != 0) || (lq.size() != 0);
      g_ld  = (lq.size() != 0) && ((aq.size() == 0) || (m_last == 1'b0));
      w     = '0;
      if (e_we) w = g_ld ? lq[0] : aq[0];
      e_stall = (m_pend[rs1] && rs1 != 0) || (m_pend[rs2] && rs2 != 0) ||
                (issue_valid && m_pend[issue_rd] && issue_rd != 0);
      chk($sformatf("r%0d.alu_ready", c), 32'(alu_ready),    32'(e_ar));
      chk($sformatf("r%0d.ld_ready", c),  32'(ld_ready),     32'(e_lr));
      chk($sformatf("r%0d.we", c),        32'(write_enable), 32'(e_we));
      chk($sformatf("r%0d.addr", c),      32'(addr_rd),      32'(w.rd));
      chk($sformatf("r%0d.data", c),      data_rd,           w.data);
      chk($sformatf("r%0d.stall", c),     32'(stall),        32'(e_stall));
      if (e_we) begin
        if (g_ld) void'(lq.pop_front());
        else      void'(aq.pop_front());
        m_last = g_ld;
        m_pend[w.rd] = 1'b0;
      end
      if (issue_valid && !e_stall && issue_rd != 0) m_pend[issue_rd] = 1'b1;
      if (alu_valid && e_ar && alu_rd != 0) aq.push_back({alu_rd, alu_data});
      if (ld_valid && e_lr && ld_rd != 0)   lq.push_back({ld_rd, ld_data});
      @(posedge clock); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2: entries per source queue, a power of two, at least 2.
REQ-002 SHALL have parameter XLEN, default 32: writeback data width.
REQ-003 SHALL have port clock  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports alu_valid / alu_rd / alu_data  input  1/5/XLEN  ALU writeback request.
REQ-006 SHALL have port alu_ready  output  1  ALU queue can accept.
REQ-007 SHALL have ports ld_valid / ld_rd / ld_data  input  1/5/XLEN  load writeback request.
REQ-008 SHALL have port ld_ready  output  1  load queue can accept.
REQ-009 SHALL have ports issue_valid / issue_rd  input  1/5  instruction issued; rd marked pending.
REQ-010 SHALL have ports rs1 / rs2  input  5/5  source registers of the decoding instruction.
REQ-011 SHALL have port stall  output  1  hazard; decode holds.
REQ-012 SHALL have ports write_enable / addr_rd / data_rd  output  1/5/XLEN  register file write port.

Function
REQ-013 SHALL accept a request when valid and ready are both high at a rising edge; ready = queue count < DEPTH, derived only from registered state.
REQ-014 SHALL keep one FIFO per source, DEPTH entries, with wrapping read/write pointers and a count; accept and drain in the same cycle on a full queue is not allowed, because ready is low.
REQ-015 SHALL consume a request with rd = 0 on accept without enqueuing it, and SHALL never assert write_enable for x0.
REQ-016 SHALL drive the write port combinationally from the queue heads only: write_enable = either queue non-empty; minimum latency from accept to write_enable is 1 cycle.
REQ-017 SHALL arbitrate round-robin when both heads are valid: grant the source not granted last; the last-grant flag updates only on a grant.
REQ-018 SHALL grant the only non-empty queue when just one is non-empty, regardless of the last-grant flag.
REQ-019 SHALL pop the granted head at the edge ending the write cycle; exactly one write per cycle.
REQ-020 SHALL keep a 32-bit pending scoreboard: bit issue_rd set on issue_valid with issue_rd != 0 and stall = 0; bit addr_rd cleared on a write.
REQ-021 SHALL resolve a same-cycle set and clear of the same bit as set.
REQ-022 SHALL compute stall = (pending[rs1] and rs1 != 0) or (pending[rs2] and rs2 != 0) or (issue_valid and pending[issue_rd] and issue_rd != 0) (WAW).
REQ-023 SHALL ignore issue_valid while stall = 1; the scoreboard is unchanged.
REQ-024 SHALL not forward: a register written in cycle N clears its pending bit at the end of N; stall deasserts in N+1.

Reset
REQ-025 SHALL, on reset asserted, asynchronously clear: both queues empty, all pointers and counts 0, pending = 0, last-grant = load (so ALU wins first tie).
REQ-026 SHALL output during and after reset, until first accept: alu_ready = ld_ready = 1, write_enable = 0, addr_rd = 0, data_rd = 0, stall = 0.
REQ-027 SHALL discard queued writes when reset is asserted mid-operation; no write_enable in the cycle of, or the cycle after, the reset edge.

Structure
REQ-028 SHALL place in the shared core package: the writeback request record (rd, data), source select encoding (SRC_ALU = 0, SRC_LD = 1), and register-index width 5.
REQ-029 SHALL implement the queue as one sub-module, wb_fifo, instanced twice; arbiter and scoreboard stay in rf_wb_arbiter.

Verification
REQ-030 SHALL cover single ALU write: ALU rd = 5, data 0xDEADBEEF at edge 0 -> cycle 1 write_enable = 1, addr_rd = 5, data_rd = 0xDEADBEEF; cycle 2 write_enable = 0.
REQ-031 SHALL cover tie: ALU (rd 1, 0x11) and load (rd 2, 0x22) accepted on the same edge after reset -> write rd 1 then rd 2 on consecutive cycles.
REQ-032 SHALL cover backpressure: 2 ALU accepts with no drain, load queue busy -> alu_ready = 0 with count 2; third alu_valid is not accepted; data is preserved in order.
REQ-033 SHALL cover hazard: issue rd = 7; next cycle rs1 = 7 -> stall = 1; load writes rd 7 in cycle N -> stall = 0 in N+1.
REQ-034 SHALL cover x0: alu_rd = 0 accepted -> no write_enable; issue_rd = 0 -> pending unchanged; rs1 = 0 -> stall = 0.
REQ-035 SHALL cover reset mid-operation: reset with both queues holding 2 entries and pending[3] = 1 -> write_enable = 0 immediately, both ready = 1, stall = 0 for rs1 = 3.
